// File: rtl/apb_gpio_irq_pkg.sv
// Shared register map, interrupt encodings and offset decode for the APB GPIO
// block with per-pin interrupt detection.
package apb_gpio_irq_pkg;

  localparam logic [5:0] OFF_OUT    = 6'h00;
  localparam logic [5:0] OFF_DIR    = 6'h04;
  localparam logic [5:0] OFF_IN     = 6'h08;
  localparam logic [5:0] OFF_SET    = 6'h0C;
  localparam logic [5:0] OFF_CLR    = 6'h10;
  localparam logic [5:0] OFF_IEN    = 6'h14;
  localparam logic [5:0] OFF_ITYPE  = 6'h18;
  localparam logic [5:0] OFF_IPOL   = 6'h1C;
  localparam logic [5:0] OFF_STATUS = 6'h20;

  localparam logic ITYPE_LEVEL = 1'b0;
  localparam logic ITYPE_EDGE  = 1'b1;
  localparam logic IPOL_LOW    = 1'b0;
  localparam logic IPOL_HIGH   = 1'b1;

  typedef enum logic [3:0] {
    REG_OUT,
    REG_DIR,
    REG_IN,
    REG_SET,
    REG_CLR,
    REG_IEN,
    REG_ITYPE,
    REG_IPOL,
    REG_STATUS,
    REG_NONE
  } reg_sel_e;

  function automatic reg_sel_e decode_offset(input logic [5:0] off);
    reg_sel_e sel;
    unique case (off)
      OFF_OUT:    sel = REG_OUT;
      OFF_DIR:    sel = REG_DIR;
      OFF_IN:     sel = REG_IN;
      OFF_SET:    sel = REG_SET;
      OFF_CLR:    sel = REG_CLR;
      OFF_IEN:    sel = REG_IEN;
      OFF_ITYPE:  sel = REG_ITYPE;
      OFF_IPOL:   sel = REG_IPOL;
      OFF_STATUS: sel = REG_STATUS;
      default:    sel = REG_NONE;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/gpio_sync.sv
// Two-flop synchronizer bringing the asynchronous pin inputs into pclk.
module gpio_sync #(
  parameter int WIDTH = 1
) (
  input  logic             pclk,
  input  logic             preset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q;

  always_ff @(posedge pclk) begin
    if (preset) begin
      meta_q <= '0;
      q      <= '0;
    end else begin
      meta_q <= d;
      q      <= meta_q;
    end
  end

endmodule

// File: rtl/apb_gpio_irq.sv
// APB3 GPIO controller: output/direction registers, synchronized inputs and
// per-pin edge/level interrupt detection into a W1C status register.
module apb_gpio_irq
  import apb_gpio_irq_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 8,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    GPIO_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input  logic                  pclk,
  input  logic                  preset,
  input  logic [ADDR_WIDTH-1:0] paddr,
  input  logic                  psel,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [DATA_WIDTH-1:0] pwdata,
  output logic [DATA_WIDTH-1:0] prdata,
  output logic                  pready,
  output logic                  pslverr,
  input  logic [GPIO_WIDTH-1:0] gpio_in,
  output logic [GPIO_WIDTH-1:0] gpio_out,
  output logic [GPIO_WIDTH-1:0] gpio_out_en,
  output logic                  irq
);

  logic [GPIO_WIDTH-1:0] out_q;
  logic [GPIO_WIDTH-1:0] dir_q;
  logic [GPIO_WIDTH-1:0] ien_q;
  logic [GPIO_WIDTH-1:0] itype_q;
  logic [GPIO_WIDTH-1:0] ipol_q;
  logic [GPIO_WIDTH-1:0] status_q;
  logic [GPIO_WIDTH-1:0] status_d;
  logic [GPIO_WIDTH-1:0] sync_q;
  logic [GPIO_WIDTH-1:0] prev_q;
  logic [GPIO_WIDTH-1:0] pol_hit;
  logic [GPIO_WIDTH-1:0] evt;
  logic [GPIO_WIDTH-1:0] w1c;
  logic [GPIO_WIDTH-1:0] wdata;
  logic [GPIO_WIDTH-1:0] rdata_g;

  logic     access;
  logic     in_block;
  logic     aligned;
  logic     err;
  logic     wr_ok;
  reg_sel_e sel;

  gpio_sync #(
    .WIDTH (GPIO_WIDTH)
  ) u_sync (
    .pclk   (pclk),
    .preset (preset),
    .d      (gpio_in),
    .q      (sync_q)
  );

  // Block occupies a 64-byte window; anything else under psel is an error.
  assign access   = psel & penable;
  assign in_block = (paddr[ADDR_WIDTH-1:6] == BASE_ADDR[ADDR_WIDTH-1:6]);
  assign aligned  = (paddr[1:0] == 2'b00);
  assign wdata    = pwdata[GPIO_WIDTH-1:0];

  always_comb begin
    sel = REG_NONE;
    if (in_block && aligned) begin
      sel = decode_offset(paddr[5:0]);
    end
    err   = access & ((sel == REG_NONE) | (pwrite & (sel == REG_IN)));
    wr_ok = access & pwrite & ~err;
  end

  always_comb begin
    rdata_g = '0;
    unique case (sel)
      REG_OUT:    rdata_g = out_q;
      REG_DIR:    rdata_g = dir_q;
      REG_IN:     rdata_g = sync_q;
      REG_IEN:    rdata_g = ien_q;
      REG_ITYPE:  rdata_g = itype_q;
      REG_IPOL:   rdata_g = ipol_q;
      REG_STATUS: rdata_g = status_q;
      default:    rdata_g = '0;
    endcase
  end

  // A transfer caught by reset is aborted silently, so responses are masked.
  assign prdata  = (access && !err && !preset) ? DATA_WIDTH'(rdata_g) : '0;
  assign pslverr = err & ~preset;
  assign pready  = 1'b1;

  always_comb begin
    pol_hit = '0;
    evt     = '0;
    for (int i = 0; i < GPIO_WIDTH; i++) begin
      unique case (ipol_q[i])
        IPOL_HIGH: pol_hit[i] = sync_q[i];
        IPOL_LOW:  pol_hit[i] = ~sync_q[i];
      endcase
      unique case (itype_q[i])
        ITYPE_EDGE:  evt[i] = pol_hit[i] & (sync_q[i] ^ prev_q[i]);
        ITYPE_LEVEL: evt[i] = pol_hit[i];
      endcase
    end
  end

  // OR-ing the event after the clear makes a same-cycle set win over W1C.
  assign w1c      = (wr_ok && (sel == REG_STATUS)) ? wdata : '0;
  assign status_d = (status_q & ~w1c) | evt;

  always_ff @(posedge pclk) begin
    if (preset) begin
      out_q    <= '0;
      dir_q    <= '0;
      ien_q    <= '0;
      itype_q  <= '0;
      ipol_q   <= '0;
      status_q <= '0;
      prev_q   <= '0;
    end else begin
      prev_q   <= sync_q;
      status_q <= status_d;
      if (wr_ok) begin
        unique case (sel)
          REG_OUT:   out_q   <= wdata;
          REG_DIR:   dir_q   <= wdata;
          REG_SET:   out_q   <= out_q | wdata;
          REG_CLR:   out_q   <= out_q & ~wdata;
          REG_IEN:   ien_q   <= wdata;
          REG_ITYPE: itype_q <= wdata;
          REG_IPOL:  ipol_q  <= wdata;
          default:   ;
        endcase
      end
    end
  end

  assign gpio_out    = out_q;
  assign gpio_out_en = dir_q;
  assign irq         = |(status_q & ien_q);

  generate
    if (DATA_WIDTH > GPIO_WIDTH) begin : g_unused
      logic unused_pwdata;
      assign unused_pwdata = ^pwdata[DATA_WIDTH-1:GPIO_WIDTH];
    end
  endgenerate

endmodule

// File: tb/tb_apb_gpio_irq.sv
// Directed bench for apb_gpio_irq with a per-cycle reference model compare.
module tb_apb_gpio_irq;

  localparam int GW = 16;

  logic        pclk = 1'b0;
  logic        preset;
  logic [7:0]  paddr;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;
  logic [GW-1:0] gpio_in;
  logic [GW-1:0] gpio_out;
  logic [GW-1:0] gpio_out_en;
  logic        irq;

  int checks = 0;
  int errors = 0;

  apb_gpio_irq dut (
    .pclk        (pclk),
    .preset      (preset),
    .paddr       (paddr),
    .psel        (psel),
    .penable     (penable),
    .pwrite      (pwrite),
    .pwdata      (pwdata),
    .prdata      (prdata),
    .pready      (pready),
    .pslverr     (pslverr),
    .gpio_in     (gpio_in),
    .gpio_out    (gpio_out),
    .gpio_out_en (gpio_out_en),
    .irq         (irq)
  );

  always #5 pclk = ~pclk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: register contents plus a history of input samples.
  logic [GW-1:0] m_out, m_dir, m_ien, m_itype, m_ipol, m_status;
  logic [GW-1:0] m_hist [3];  // m_hist[k]: gpio_in sampled k+1 edges ago

  function automatic int reg_index(input logic [7:0] a);
    if (a[1:0] != 2'b00 || a > 8'h20) return -1;
    return int'(a) / 4;
  endfunction

  always @(posedge pclk) begin : model
    logic [GW-1:0] sync, prev, ev, clr, wd;
    int r;
    if (preset) begin
      m_out = '0; m_dir = '0; m_ien = '0; m_itype = '0; m_ipol = '0; m_status = '0;
      m_hist = '{default: '0};
    end else begin
      sync = m_hist[1];
      prev = m_hist[2];
      ev   = '0;
      for (int i = 0; i < GW; i++) begin
        if (sync[i] == m_ipol[i]) ev[i] = m_itype[i] ? (sync[i] != prev[i]) : 1'b1;
      end
      clr = '0;
      if (psel && penable && pwrite) begin
        r  = reg_index(paddr);
        wd = pwdata[GW-1:0];
        case (r)
          0: m_out   = wd;
          1: m_dir   = wd;
          3: m_out   = m_out | wd;
          4: m_out   = m_out & ~wd;
          5: m_ien   = wd;
          6: m_itype = wd;
          7: m_ipol  = wd;
          8: clr     = wd;
          default: ;
        endcase
      end
      m_status  = (m_status & ~clr) | ev;
      m_hist[2] = m_hist[1];
      m_hist[1] = m_hist[0];
      m_hist[0] = gpio_in;
    end
  end

  always @(posedge pclk) begin : compare
    logic [31:0] exp_rd;
    logic        exp_err;
    int r;
    #2;
    exp_rd  = '0;
    exp_err = 1'b0;
    if (!preset && psel && penable) begin
      r = reg_index(paddr);
      if (r < 0 || (pwrite && r == 2)) exp_err = 1'b1;
      else begin
        case (r)
          0: exp_rd = {16'h0, m_out};
          1: exp_rd = {16'h0, m_dir};
          2: exp_rd = {16'h0, m_hist[1]};
          5: exp_rd = {16'h0, m_ien};
          6: exp_rd = {16'h0, m_itype};
          7: exp_rd = {16'h0, m_ipol};
          8: exp_rd = {16'h0, m_status};
          default: exp_rd = '0;
        endcase
      end
    end
    chk("cyc_gpio_out", {16'h0, gpio_out}, {16'h0, m_out});
    chk("cyc_gpio_out_en", {16'h0, gpio_out_en}, {16'h0, m_dir});
    chk("cyc_irq", {31'h0, irq}, {31'h0, |(m_status & m_ien)});
    chk("cyc_pready", {31'h0, pready}, 32'h1);
    chk("cyc_pslverr", {31'h0, pslverr}, {31'h0, exp_err});
    chk("cyc_prdata", prdata, exp_rd);
  end

  task automatic apb_write(input logic [7:0] a, input logic [31:0] d, output logic err);
    @(negedge pclk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
    @(negedge pclk);
    penable = 1'b1;
    #1 err = pslverr;
    @(negedge pclk);
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0; pwdata = '0;
  endtask

  task automatic apb_read(input logic [7:0] a, output logic [31:0] d, output logic err);
    @(negedge pclk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
    @(negedge pclk);
    penable = 1'b1;
    #1 begin d = prdata; err = pslverr; end
    @(negedge pclk);
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    logic e;
    apb_write(a, d, e);
    chk("wr_err", {31'h0, e}, 32'h0);
  endtask

  task automatic rd_chk(input string name, input logic [7:0] a, input logic [31:0] exp);
    logic [31:0] d;
    logic e;
    apb_read(a, d, e);
    chk(name, d, exp);
    chk({name, "_err"}, {31'h0, e}, 32'h0);
  endtask

  initial begin : timeout
    #200000;
    $display("FAIL timeout: simulation did not reach the end");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [31:0] d;
    logic e;
    preset = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; gpio_in = '0;
    repeat (3) @(posedge pclk);
    @(negedge pclk);
    chk("rst_gpio_out", {16'h0, gpio_out}, 32'h0);
    chk("rst_gpio_out_en", {16'h0, gpio_out_en}, 32'h0);
    chk("rst_irq", {31'h0, irq}, 32'h0);
    preset = 1'b0;

    // all pins rising-edge, then flush the level-low hits gathered after reset
    wr(8'h18, 32'hFFFF);
    wr(8'h1C, 32'hFFFF);
    wr(8'h20, 32'hFFFF);
    rd_chk("status_clean", 8'h20, 32'h0);
    rd_chk("in_zero", 8'h08, 32'h0);

    wr(8'h04, 32'hFFFF);
    wr(8'h00, 32'h00A5);
    chk("out_a5", {16'h0, gpio_out}, 32'h00A5);
    chk("dir_ffff", {16'h0, gpio_out_en}, 32'hFFFF);
    wr(8'h0C, 32'h0100);
    chk("set_0100", {16'h0, gpio_out}, 32'h01A5);
    wr(8'h10, 32'h0005);
    chk("clr_0005", {16'h0, gpio_out}, 32'h01A0);
    wr(8'h0C, 32'hFFFF0000);
    chk("set_upper_ignored", {16'h0, gpio_out}, 32'h01A0);
    rd_chk("rd_out", 8'h00, 32'h01A0);
    rd_chk("rd_set_zero", 8'h0C, 32'h0);

    // rising edge on pin 3: irq on exactly the third edge
    wr(8'h14, 32'h0008);
    @(negedge pclk);
    gpio_in = 16'h0008;
    for (int k = 1; k <= 3; k++) begin
      @(posedge pclk);
      #2 chk($sformatf("edge3_irq_e%0d", k), {31'h0, irq}, (k == 3) ? 32'h1 : 32'h0);
    end
    rd_chk("status_0008", 8'h20, 32'h0008);
    wr(8'h20, 32'h0008);
    chk("w1c_irq_low", {31'h0, irq}, 32'h0);
    rd_chk("status_cleared", 8'h20, 32'h0);

    // level-high pin 0 held: W1C loses to the continuous set
    wr(8'h14, 32'h0001);
    wr(8'h18, 32'hFFFE);
    @(negedge pclk);
    gpio_in = 16'h0009;
    repeat (4) @(posedge pclk);
    #2 chk("level_irq", {31'h0, irq}, 32'h1);
    wr(8'h20, 32'h0001);
    rd_chk("set_wins", 8'h20, 32'h0001);
    @(negedge pclk);
    gpio_in = 16'h0008;
    wr(8'h18, 32'hFFFF);
    wr(8'h20, 32'hFFFF);
    rd_chk("status_clean2", 8'h20, 32'h0);
    chk("irq_clean2", {31'h0, irq}, 32'h0);

    // error responses leave state alone
    apb_read(8'h24, d, e);
    chk("unmapped_err", {31'h0, e}, 32'h1);
    chk("unmapped_rd", d, 32'h0);
    apb_write(8'h08, 32'hFFFF, e);
    chk("wr_in_err", {31'h0, e}, 32'h1);
    rd_chk("in_unchanged", 8'h08, 32'h0008);
    apb_write(8'h01, 32'hFFFF, e);
    chk("misalign_wr_err", {31'h0, e}, 32'h1);
    apb_read(8'h01, d, e);
    chk("misalign_rd_err", {31'h0, e}, 32'h1);
    chk("misalign_rd", d, 32'h0);
    rd_chk("out_unchanged", 8'h00, 32'h01A0);

    // falling-edge pulse on pin 5 with IEN off, then enable it
    wr(8'h1C, 32'hFFDF);
    @(negedge pclk);
    gpio_in = 16'h0028;
    repeat (3) @(negedge pclk);
    gpio_in = 16'h0008;
    repeat (4) @(negedge pclk);
    chk("fall_irq_masked", {31'h0, irq}, 32'h0);
    rd_chk("status_0020", 8'h20, 32'h0020);
    wr(8'h14, 32'h0021);
    chk("fall_irq_enabled", {31'h0, irq}, 32'h1);

    // reset lands on the access phase of an OUT write
    @(negedge pclk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h00; pwdata = 32'h1234;
    @(negedge pclk);
    penable = 1'b1; preset = 1'b1;
    #1 begin
      chk("rst_mid_pslverr", {31'h0, pslverr}, 32'h0);
      chk("rst_mid_pready", {31'h0, pready}, 32'h1);
    end
    @(negedge pclk);
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0; pwdata = '0;
    chk("rst_mid_out", {16'h0, gpio_out}, 32'h0);
    chk("rst_mid_en", {16'h0, gpio_out_en}, 32'h0);
    chk("rst_mid_irq", {31'h0, irq}, 32'h0);
    @(negedge pclk);
    preset = 1'b0;
    rd_chk("out_after_rst", 8'h00, 32'h0);
    rd_chk("status_level_low", 8'h20, 32'hFFFF);
    chk("irq_after_rst", {31'h0, irq}, 32'h0);

    repeat (3) @(negedge pclk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/apb_gpio_irq.md
APB_GPIO_IRQ -- requirements
Module: apb_gpio_irq

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 8: APB address width; byte addresses, word-aligned registers.
REQ-002 SHALL have parameter DATA_WIDTH, default 32: APB data width.
REQ-003 SHALL have parameter GPIO_WIDTH, default 16, legal 1..DATA_WIDTH: number of pins.
REQ-004 SHALL have parameter BASE_ADDR, default 8'h00: block base address, aligned to 64 bytes.
REQ-005 SHALL have port pclk, input, 1: the single clock; all logic on its rising edge.
REQ-006 SHALL have port preset, input, 1: reset, synchronous and active-high.
REQ-007 SHALL have APB3 slave ports: paddr in ADDR_WIDTH, psel in 1, penable in 1, pwrite in 1, pwdata in DATA_WIDTH, prdata out DATA_WIDTH, pready out 1, pslverr out 1.
REQ-008 SHALL have port gpio_in, input, GPIO_WIDTH: asynchronous pin inputs.
REQ-009 SHALL have port gpio_out, output, GPIO_WIDTH: pin output values, equal to the OUT register.
REQ-010 SHALL have port gpio_out_en, output, GPIO_WIDTH: per-pin output enable, equal to the DIR register.
REQ-011 SHALL have port irq, output, 1: level interrupt, equal to |(STATUS & IEN).

Function
REQ-012 SHALL decode offsets from BASE_ADDR: 0x00 OUT rw, 0x04 DIR rw, 0x08 IN ro, 0x0C SET wo, 0x10 CLR wo, 0x14 IEN rw, 0x18 ITYPE rw (1=edge, 0=level), 0x1C IPOL rw (1=rising/high, 0=falling/low), 0x20 STATUS rw1c.
REQ-013 SHALL have zero wait states: pready=1 at all times.
REQ-014 SHALL commit writes on the rising edge ending the access phase (psel & penable & pwrite).
REQ-015 SHALL drive prdata combinationally during the access phase from the addressed register, zero-extended from GPIO_WIDTH; prdata SHALL be 0 outside the access phase.
REQ-016 SHALL return 0 on reads of SET and CLR.
REQ-017 SHALL assert pslverr in the access phase for an unmapped offset, a write to IN, or a misaligned paddr[1:0]!=0; no state SHALL change and prdata SHALL be 0.
REQ-018 SHALL OR pwdata into OUT on a SET write and clear OUT bits where pwdata=1 on a CLR write.
REQ-019 SHALL pass gpio_in through a 2-flop synchronizer; IN SHALL read the synchronized value for every pin regardless of DIR.
REQ-020 SHALL keep a third flop (prev) of the synchronized input for edge detection.
REQ-021 SHALL, for an edge bit, set STATUS when sync != prev and sync == IPOL.
REQ-022 SHALL, for a level bit, set STATUS on every cycle where sync == IPOL.
REQ-023 SHALL set a STATUS bit on the 3rd rising edge after gpio_in changes (sampled on edge 1); irq SHALL follow STATUS/IEN combinationally.
REQ-024 SHALL detect into STATUS regardless of IEN; IEN gates irq only.
REQ-025 SHALL clear STATUS bits where a STATUS write has pwdata=1; when a set event and a W1C hit the same bit in the same cycle, set SHALL win.
REQ-026 SHALL ignore pwdata bits at or above GPIO_WIDTH.
REQ-027 SHALL NOT set STATUS from ITYPE or IPOL writes alone on the write cycle; detection SHALL use the new configuration from the next cycle.

Reset
REQ-028 SHALL, while preset=1 at a rising edge, clear OUT, DIR, IEN, ITYPE, IPOL, STATUS, the synchronizer and prev flops; gpio_out=0, gpio_out_en=0, irq=0.
REQ-029 SHALL abort any in-flight APB transfer on reset with no register update; pready SHALL remain 1 and pslverr 0.
REQ-030 SHALL prevent a false edge event in the first two cycles after reset release.

Structure
REQ-031 SHALL place register offsets and the ITYPE/IPOL encodings in shared package apb_gpio_irq_pkg.
REQ-032 SHALL implement the synchronizer as sub-module gpio_sync (parameter WIDTH, 2 flops, synchronous active-high reset).

Verification
REQ-033 SHALL check that writing 0xFFFF to DIR and then 0x00A5 to OUT gives gpio_out=0x00A5 and gpio_out_en=0xFFFF; SET 0x0100 gives 0x01A5; CLR 0x0005 gives 0x01A0.
REQ-034 SHALL check that with ITYPE[3]=1, IPOL[3]=1, IEN[3]=1 and gpio_in[3] going 0->1, STATUS=0x0008 and irq=1 on exactly the 3rd edge; a W1C of 0x0008 then gives irq=0.
REQ-035 SHALL check that with a level-high bit 0 held at 1, a W1C of STATUS bit 0 leaves STATUS[0]=1 (set wins).
REQ-036 SHALL check that a read of offset 0x24, a write to 0x08, or paddr=0x01 gives pslverr=1, prdata=0, and no register change.
REQ-037 SHALL check that asserting preset during an access-phase write to OUT leaves OUT=0 and all outputs at reset values.
REQ-038 SHALL check that an edge-falling, IEN=0 pulse sets STATUS with irq=0, and irq=1 the cycle after IEN is written.
